// File: rtl/objective.sv
// objective -- training-side error stage behind the perceptron.
//
// Joins a result stream and a target stream, each with a one-entry holding
// register. Once both are held, it computes err = tgt - res as a signed word.
// In training mode (en=1) the error is presented on err_*. In inference mode
// (en=0) the error is computed and then dropped.
//
// Optional feature macro: OBJECTIVE_STATS_EN. When it is defined, the block
// keeps saturating counters of the sum of |err| and of the number of samples.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   en                  1 = training (present error), 0 = inference (drop it)
//   res_dat/stb/rdy     result stream from the perceptron
//   tgt_dat/stb/rdy     target stream
//   err_dat/stb/rdy     signed error back to the perceptron
//   clr                 synchronous statistics clear      (stats build only)
//   sae_dat, cnt_dat    sum of |err|, samples evaluated   (stats build only)
module objective #(
  parameter int RESW  = 8,
  parameter int ERRW  = 16,
  parameter int STATW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [RESW-1:0]   res_dat,
  input  logic              res_stb,
  output logic              res_rdy,
  input  logic [RESW-1:0]   tgt_dat,
  input  logic              tgt_stb,
  output logic              tgt_rdy,
  output logic [ERRW-1:0]   err_dat,
  output logic              err_stb,
  input  logic              err_rdy
`ifdef OBJECTIVE_STATS_EN
  ,
  input  logic              clr,
  output logic [STATW-1:0]  sae_dat,
  output logic [STATW-1:0]  cnt_dat
`endif
);

  // The error needs one extra sign bit over the operands, so it can never overflow.
  if (ERRW < RESW + 1) begin : g_bad_errw
    $error("objective: ERRW must be >= RESW+1");
  end

  logic [RESW-1:0] res_q, res_d, tgt_q, tgt_d;
  logic            res_full_q, res_full_d, tgt_full_q, tgt_full_d;
  logic [ERRW-1:0] err_q, err_d;
  logic            err_stb_q, err_stb_d;
  logic            compute;
  logic signed [ERRW-1:0] diff;

  // Zero-extend both operands into ERRW bits, then subtract them as signed values.
  assign diff = $signed({{(ERRW-RESW){1'b0}}, tgt_q}) -
                $signed({{(ERRW-RESW){1'b0}}, res_q});

  // A pending error that is being accepted frees the output register in the same cycle.
  assign compute = res_full_q && tgt_full_q && (!err_stb_q || err_rdy);

  assign res_rdy = !res_full_q;
  assign tgt_rdy = !tgt_full_q;
  assign err_dat = err_q;
  assign err_stb = err_stb_q;

  always_comb begin
    res_d      = res_q;
    tgt_d      = tgt_q;
    res_full_d = res_full_q;
    tgt_full_d = tgt_full_q;
    err_d      = err_q;
    err_stb_d  = err_stb_q;
    if (compute) begin
      res_full_d = 1'b0;
      tgt_full_d = 1'b0;
      err_d      = diff;
      err_stb_d  = en;
    end else if (err_rdy) begin
      err_stb_d  = 1'b0;
    end
    // An operand is accepted only into an empty slot. Compute needs a full slot,
    // so an accept and a compute never touch the same register in one cycle.
    if (res_stb && !res_full_q) begin
      res_full_d = 1'b1;
      res_d      = res_dat;
    end
    if (tgt_stb && !tgt_full_q) begin
      tgt_full_d = 1'b1;
      tgt_d      = tgt_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q      <= '0;
      tgt_q      <= '0;
      res_full_q <= 1'b0;
      tgt_full_q <= 1'b0;
      err_q      <= '0;
      err_stb_q  <= 1'b0;
    end else begin
      res_q      <= res_d;
      tgt_q      <= tgt_d;
      res_full_q <= res_full_d;
      tgt_full_q <= tgt_full_d;
      err_q      <= err_d;
      err_stb_q  <= err_stb_d;
    end
  end

`ifdef OBJECTIVE_STATS_EN
  logic [STATW-1:0] sae_q, sae_d, cnt_q, cnt_d, abs_ext;
  logic [ERRW-1:0]  abs_err;
  logic [STATW:0]   sae_sum, cnt_sum;

  assign abs_err = diff[ERRW-1] ? ERRW'(-diff) : ERRW'(diff);
  assign abs_ext = STATW'(abs_err);
  assign sae_sum = {1'b0, sae_q} + {1'b0, abs_ext};
  assign cnt_sum = {1'b0, cnt_q} + {{STATW{1'b0}}, 1'b1};
  assign sae_dat = sae_q;
  assign cnt_dat = cnt_q;

  always_comb begin
    sae_d = sae_q;
    cnt_d = cnt_q;
    if (compute) begin
      if (clr) begin
        // A clear in the same cycle as a compute restarts the counters from this sample.
        sae_d = abs_ext;
        cnt_d = STATW'(1);
      end else begin
        sae_d = sae_sum[STATW] ? '1 : sae_sum[STATW-1:0];
        cnt_d = cnt_sum[STATW] ? '1 : cnt_sum[STATW-1:0];
      end
    end else if (clr) begin
      sae_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sae_q <= '0;
      cnt_q <= '0;
    end else begin
      sae_q <= sae_d;
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_objective.sv
// Directed bench for objective: a table of single-pair vectors, plus hand-written
// sequences for ordering, backpressure, inference, statistics and mid-run reset.
module tb_objective;
  logic        clk = 1'b0;
  logic        rst, en;
  logic [7:0]  res_dat, tgt_dat;
  logic        res_stb, tgt_stb, err_rdy;
  logic        res_rdy, tgt_rdy, err_stb;
  logic [15:0] err_dat;
`ifdef OBJECTIVE_STATS_EN
  logic        clr;
  logic [31:0] sae_dat, cnt_dat;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  objective #(.RESW(8), .ERRW(16), .STATW(32)) dut (
    .clk(clk), .rst(rst), .en(en),
    .res_dat(res_dat), .res_stb(res_stb), .res_rdy(res_rdy),
    .tgt_dat(tgt_dat), .tgt_stb(tgt_stb), .tgt_rdy(tgt_rdy),
    .err_dat(err_dat), .err_stb(err_stb), .err_rdy(err_rdy)
`ifdef OBJECTIVE_STATS_EN
    , .clr(clr), .sae_dat(sae_dat), .cnt_dat(cnt_dat)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  tgt;
    logic [7:0]  res;
    logic        en;
    logic [15:0] err;
    logic        stb;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Presents both operands in one cycle. They are accepted at the next edge.
  task automatic send_pair(input logic [7:0] t, input logic [7:0] r);
    tgt_dat = t; res_dat = r; tgt_stb = 1'b1; res_stb = 1'b1;
    tick();
    tgt_stb = 1'b0; res_stb = 1'b0;
  endtask

  initial begin
    vecs[0] = '{8'hff, 8'h00, 1'b1, 16'h00ff, 1'b1};
    vecs[1] = '{8'h00, 8'hff, 1'b1, 16'hff01, 1'b1};
    vecs[2] = '{8'h80, 8'h7f, 1'b1, 16'h0001, 1'b1};
    vecs[3] = '{8'h7f, 8'h80, 1'b1, 16'hffff, 1'b1};
    vecs[4] = '{8'h55, 8'h55, 1'b1, 16'h0000, 1'b1};
    vecs[5] = '{8'hc8, 8'h32, 1'b0, 16'h0096, 1'b0};

    rst = 1'b1; en = 1'b1; res_dat = '0; tgt_dat = '0;
    res_stb = 1'b0; tgt_stb = 1'b0; err_rdy = 1'b0;
`ifdef OBJECTIVE_STATS_EN
    clr = 1'b0;
`endif
    tick(); tick();
    rst = 1'b0;
    chk("rst res_rdy", res_rdy, 1);
    chk("rst tgt_rdy", tgt_rdy, 1);
    chk("rst err_stb", err_stb, 0);
    chk("rst err_dat", err_dat, 0);
`ifdef OBJECTIVE_STATS_EN
    chk("rst sae", sae_dat, 0);
    chk("rst cnt", cnt_dat, 0);
`endif

    // Table: pair at edge k, error visible after edge k+1, held while err_rdy=0.
    foreach (vecs[i]) begin
      en = vecs[i].en; err_rdy = 1'b0;
      send_pair(vecs[i].tgt, vecs[i].res);
      chk("tbl early stb", err_stb, 0);
      chk("tbl res_rdy busy", res_rdy, 0);
      chk("tbl tgt_rdy busy", tgt_rdy, 0);
      tick();
      chk("tbl err_stb", err_stb, vecs[i].stb);
      chk("tbl err_dat", err_dat, vecs[i].err);
      chk("tbl rdy back", {res_rdy, tgt_rdy}, 2'b11);
      tick();
      chk("tbl hold stb", err_stb, vecs[i].stb);
      chk("tbl hold dat", err_dat, vecs[i].err);
      err_rdy = 1'b1;
      tick();
      chk("tbl accept stb", err_stb, 0);
      err_rdy = 1'b0;
    end

    // Ordering: the target arrives 3 cycles before the result.
    en = 1'b1;
    tgt_dat = 8'h00; tgt_stb = 1'b1;
    tick();
    tgt_stb = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("ord tgt_rdy wait", tgt_rdy, 0);
      chk("ord res_rdy wait", res_rdy, 1);
      chk("ord no stb", err_stb, 0);
      if (c < 2) tick();
    end
    res_dat = 8'hff; res_stb = 1'b1;
    tick();
    res_stb = 1'b0;
    tick();
    chk("ord err_stb", err_stb, 1);
    chk("ord err_dat", err_dat, 16'hff01);
    err_rdy = 1'b1;
    tick();
    err_rdy = 1'b0;

    // Backpressure: the second pair waits in the holding registers until the first error is accepted.
    send_pair(8'h20, 8'h10);
    tick();
    chk("bp first stb", err_stb, 1);
    chk("bp first dat", err_dat, 16'h0010);
    send_pair(8'h05, 8'h08);
    for (int c = 0; c < 5; c++) begin
      chk("bp hold dat", err_dat, 16'h0010);
      chk("bp hold stb", err_stb, 1);
      chk("bp stall rdy", {res_rdy, tgt_rdy}, 2'b00);
      tick();
    end
    err_rdy = 1'b1;
    tick();
    chk("bp second stb", err_stb, 1);
    chk("bp second dat", err_dat, 16'hfffd);
    chk("bp rdy free", {res_rdy, tgt_rdy}, 2'b11);
    tick();
    chk("bp drained", err_stb, 0);
    err_rdy = 1'b0;

    // Inference: four equal pairs with en=0.
`ifdef OBJECTIVE_STATS_EN
    clr = 1'b1; tick(); clr = 1'b0;
`endif
    en = 1'b0;
    for (int p = 0; p < 4; p++) begin
      send_pair(8'(p * 3), 8'(p * 3));
      tick();
      chk("inf err_stb", err_stb, 0);
      chk("inf rdy", {res_rdy, tgt_rdy}, 2'b11);
    end
`ifdef OBJECTIVE_STATS_EN
    chk("inf cnt", cnt_dat, 4);
    chk("inf sae", sae_dat, 0);

    // Statistics: errors +10, -20, +5, then a clear that coincides with a compute of -7.
    en = 1'b1; err_rdy = 1'b1;
    clr = 1'b1; tick(); clr = 1'b0;
    send_pair(8'd20, 8'd10); tick();
    send_pair(8'd10, 8'd30); tick();
    send_pair(8'd15, 8'd10); tick();
    tick();
    chk("st sae", sae_dat, 35);
    chk("st cnt", cnt_dat, 3);
    send_pair(8'd3, 8'd10);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("st clr sae", sae_dat, 7);
    chk("st clr cnt", cnt_dat, 1);
    tick();
    err_rdy = 1'b0;
`endif

    // Reset mid-operation: an error is pending and the result register is full.
    en = 1'b1; err_rdy = 1'b0;
    send_pair(8'h40, 8'h01);
    tick();
    chk("mr pre stb", err_stb, 1);
    res_dat = 8'h77; res_stb = 1'b1;
    tick();
    res_stb = 1'b0;
    chk("mr res full", res_rdy, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr err_stb", err_stb, 0);
    chk("mr rdy", {res_rdy, tgt_rdy}, 2'b11);
    chk("mr err_dat", err_dat, 0);
    send_pair(8'h03, 8'h01);
    tick();
    chk("mr new stb", err_stb, 1);
    chk("mr new dat", err_dat, 16'h0002);
`ifdef OBJECTIVE_STATS_EN
    chk("mr cnt", cnt_dat, 1);
    chk("mr sae", sae_dat, 2);
`endif
    err_rdy = 1'b1;
    tick();
    chk("mr drained", err_stb, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
